fifo_mst_rd_check: RTL and testbench

- FT60x 245-mode synchronous FIFO master read stage for the 16-bit data-stream test.
- Sits beside the master-write pattern generator on the same FT bus. Drains host-to-FPGA bursts and checks each word against an incrementing 16-bit pattern.
- Reports word and error counts to the status/LED logic. Can optionally forward received words to the write side as a loopback source.

---
 rtl/fifo_mst_rd_check.sv | 188 ++++++++++++++++++
 tb/tb_fifo_mst_rd_check.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mst_rd_check.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_mst_rd_check
//   FT60x 245-mode synchronous FIFO master read stage for the 16-bit stream
//   test. Drains host-to-FPGA bursts and checks every full word against an
//   incrementing 16-bit pattern. The first full word after reset or clr
//   seeds the pattern.
//
//   Optional feature: define FIFO_RD_FWD_EN to add a loopback forwarding
//   port (fwd_valid/fwd_data out, fwd_ready in). With the macro undefined
//   those ports do not exist.
//
// Parameters
//   MAX_BURST  maximum beats per burst before the bus is released (2..65535)
//   CNT_W      width of the word / error counters
//
// Ports
//   CLK            FT bus clock, the only clock
//   RESETN         asynchronous active-low reset
//   RXF_N          FT60x receive FIFO not empty, active low
//   DATA, BE       FT bus data and byte enables, sampled on accepted beats
//   clr            synchronous clear of statistics and pattern seed
//   OE_N, RD_N     bus output enable / read strobe to the FT60x, active low
//   rd_busy        high while the read FSM is outside IDLE
//   word_cnt       full-BE words accepted (wraps)
//   err_cnt        pattern mismatches (saturating)
//   be_err_cnt     beats with BE != 2'b11 (saturating)
//   first_err      sticky flag, set on the first mismatch
//   first_err_exp  expected word at the first mismatch
//   first_err_got  received word at the first mismatch
//   fwd_valid      (FIFO_RD_FWD_EN) one-cycle strobe after each full-BE beat
//   fwd_data       (FIFO_RD_FWD_EN) word accepted on that beat
//   fwd_ready      (FIFO_RD_FWD_EN) loopback sink ready; low ends the burst
// -----------------------------------------------------------------------------
module fifo_mst_rd_check #(
    parameter int MAX_BURST = 512,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             RXF_N,
    input  logic [15:0]      DATA,
    input  logic [1:0]       BE,
    input  logic             clr,
`ifdef FIFO_RD_FWD_EN
    input  logic             fwd_ready,
    output logic             fwd_valid,
    output logic [15:0]      fwd_data,
`endif
    output logic             OE_N,
    output logic             RD_N,
    output logic             rd_busy,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] be_err_cnt,
    output logic             first_err,
    output logic [15:0]      first_err_exp,
    output logic [15:0]      first_err_got
);

    localparam int               BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OE,
        S_READ,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BURST_W-1:0] burst_cnt;
    logic               beat;
    logic               last_beat;
    logic               full_word;
    logic               fwd_stall;
    logic               oe_n_nxt;
    logic               rd_n_nxt;
    logic               seeded;
    logic [15:0]        exp_word;

`ifdef FIFO_RD_FWD_EN
    assign fwd_stall = !fwd_ready;
`else
    assign fwd_stall = 1'b0;
`endif

    // RD_N is low exactly while the registered state is READ, so a beat is
    // READ with data available and (when forwarding) the sink ready.
    assign beat      = (state == S_READ) && !RXF_N && !fwd_stall;
    assign last_beat = beat && (burst_cnt == BURST_W'(MAX_BURST - 1));
    assign full_word = (BE == 2'b11);

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!RXF_N) next_state = S_OE;
            S_OE:    next_state = S_READ;
            S_READ:  if (RXF_N || fwd_stall || last_beat) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        // Bus strobes are decoded from the next state and registered so they
        // change on the same edge as the state itself.
        oe_n_nxt = !((next_state == S_OE) || (next_state == S_READ));
        rd_n_nxt = (next_state != S_READ);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= S_IDLE;
            OE_N      <= 1'b1;
            RD_N      <= 1'b1;
            rd_busy   <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state   <= next_state;
            OE_N    <= oe_n_nxt;
            RD_N    <= rd_n_nxt;
            rd_busy <= (next_state != S_IDLE);
            if (next_state == S_OE) begin
                burst_cnt <= '0;
            end else if (beat) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
        end
    end

    // Pattern checker. clr wins over a same-edge beat, dropping that beat.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            word_cnt      <= '0;
            err_cnt       <= '0;
            be_err_cnt    <= '0;
            first_err     <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            seeded        <= 1'b0;
            exp_word      <= '0;
        end else if (clr) begin
            word_cnt      <= '0;
            err_cnt       <= '0;
            be_err_cnt    <= '0;
            first_err     <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            seeded        <= 1'b0;
            exp_word      <= '0;
        end else if (beat) begin
            if (!full_word) begin
                if (be_err_cnt != CNT_MAX) be_err_cnt <= be_err_cnt + CNT_W'(1);
            end else begin
                word_cnt <= word_cnt + CNT_W'(1);
                seeded   <= 1'b1;
                // Seed, match (DATA == exp_word) and resync after a mismatch
                // all leave the next expected word at DATA + 1.
                exp_word <= DATA + 16'd1;
                if (seeded && (DATA != exp_word)) begin
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
                    if (!first_err) begin
                        first_err     <= 1'b1;
                        first_err_exp <= exp_word;
                        first_err_got <= DATA;
                    end
                end
            end
        end
    end

`ifdef FIFO_RD_FWD_EN
    // Loopback source: forwarding is independent of clr.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            fwd_valid <= 1'b0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= beat && full_word;
            if (beat && full_word) fwd_data <= DATA;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_mst_rd_check.sv
`timescale 1ns/1ps
module tb_fifo_mst_rd_check;

    localparam int MAX_BURST = 512;
    localparam int CNT_W     = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             CLK = 1'b0;
    logic             RESETN;
    logic             RXF_N;
    logic [15:0]      DATA;
    logic [1:0]       BE;
    logic             clr;
    logic             OE_N;
    logic             RD_N;
    logic             rd_busy;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] be_err_cnt;
    logic             first_err;
    logic [15:0]      first_err_exp;
    logic [15:0]      first_err_got;
`ifdef FIFO_RD_FWD_EN
    logic             fwd_ready;
    logic             fwd_valid;
    logic [15:0]      fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    fifo_mst_rd_check #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .RXF_N         (RXF_N),
        .DATA          (DATA),
        .BE            (BE),
        .clr           (clr),
`ifdef FIFO_RD_FWD_EN
        .fwd_ready     (fwd_ready),
        .fwd_valid     (fwd_valid),
        .fwd_data      (fwd_data),
`endif
        .OE_N          (OE_N),
        .RD_N          (RD_N),
        .rd_busy       (rd_busy),
        .word_cnt      (word_cnt),
        .err_cnt       (err_cnt),
        .be_err_cnt    (be_err_cnt),
        .first_err     (first_err),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model of the statistics, built from the checker rules.
    logic [CNT_W-1:0] m_word, m_err, m_be;
    logic             m_seeded, m_first;
    logic [15:0]      m_exp, m_fexp, m_fgot;

    logic [15:0] stim_d[$];
    logic [1:0]  stim_be[$];

    function automatic void model_clear();
        m_word = '0; m_err = '0; m_be = '0;
        m_seeded = 1'b0; m_first = 1'b0;
        m_exp = '0; m_fexp = '0; m_fgot = '0;
    endfunction

    function automatic void model_beat(input logic [15:0] d, input logic [1:0] be);
        if (be != 2'b11) begin
            if (m_be != CNT_MAX) m_be = m_be + 1;
        end else begin
            m_word = m_word + 1;
            if (!m_seeded) begin
                m_seeded = 1'b1;
                m_exp    = d + 16'd1;
            end else if (d == m_exp) begin
                m_exp = m_exp + 16'd1;
            end else begin
                if (m_err != CNT_MAX) m_err = m_err + 1;
                if (!m_first) begin
                    m_first = 1'b1;
                    m_fexp  = m_exp;
                    m_fgot  = d;
                end
                m_exp = d + 16'd1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
    endtask

    // Runs one burst from IDLE: OE turnaround, READ for every queued word,
    // then RXF_N high so the FSM passes DONE back into IDLE.
    task automatic send_burst();
        RXF_N = 1'b0;
        tick();
        tick();
        while (stim_d.size() > 0) begin
            DATA = stim_d.pop_front();
            BE   = stim_be.pop_front();
            tick();
            model_beat(DATA, BE);
        end
        RXF_N = 1'b1;
        DATA  = 16'hDEAD;
        BE    = 2'b11;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        RXF_N  = 1'b1;
        DATA   = '0;
        BE     = 2'b11;
        clr    = 1'b0;
`ifdef FIFO_RD_FWD_EN
        fwd_ready = 1'b1;
`endif
        model_clear();
        #12;
        checks++;
        if ({OE_N, RD_N, rd_busy, first_err} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 1100", {OE_N, RD_N, rd_busy, first_err});
        end
        checks++;
        if ({word_cnt, err_cnt, be_err_cnt, first_err_exp, first_err_got} !== '0) begin
            errors++;
            $display("FAIL reset_stats got w=%0d e=%0d b=%0d fe=%h fg=%h exp all 0",
                     word_cnt, err_cnt, be_err_cnt, first_err_exp, first_err_got);
        end
`ifdef FIFO_RD_FWD_EN
        checks++;
        if ({fwd_valid, fwd_data} !== 17'd0) begin
            errors++;
            $display("FAIL reset_fwd got v=%b d=%h exp 0", fwd_valid, fwd_data);
        end
`endif
        @(negedge CLK);
        RESETN = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic_burst();
        RXF_N = 1'b0;
        tick();
        checks++;
        if ({OE_N, RD_N, rd_busy} !== 3'b011) begin
            errors++;
            $display("FAIL basic_oe_turnaround got %b exp 011", {OE_N, RD_N, rd_busy});
        end
        tick();
        checks++;
        if ({OE_N, RD_N} !== 2'b00) begin
            errors++;
            $display("FAIL basic_read_strobe got %b exp 00", {OE_N, RD_N});
        end
        for (int i = 0; i < 8; i++) begin
            DATA = 16'h0010 + 16'(i);
            BE   = 2'b11;
            tick();
            model_beat(DATA, BE);
        end
        // No beat may be taken on the edge where RXF_N is seen high.
        RXF_N = 1'b1;
        DATA  = 16'hDEAD;
        tick();
        checks++;
        if ({OE_N, RD_N, rd_busy} !== 3'b111) begin
            errors++;
            $display("FAIL basic_done got %b exp 111", {OE_N, RD_N, rd_busy});
        end
        tick();
        checks++;
        if ({OE_N, RD_N, rd_busy} !== 3'b110) begin
            errors++;
            $display("FAIL basic_idle got %b exp 110", {OE_N, RD_N, rd_busy});
        end
        checks++;
        if (word_cnt !== 32'd8 || err_cnt !== 32'd0 || word_cnt !== m_word) begin
            errors++;
            $display("FAIL basic_counts got w=%0d e=%0d exp w=8 e=0", word_cnt, err_cnt);
        end
    endtask

    task automatic test_max_burst();
        logic [15:0] d;
        pulse_clr();
        d = 16'($urandom);
        RXF_N = 1'b0;
        tick();
        tick();
        for (int b = 0; b < 2; b++) begin
            for (int k = 1; k <= MAX_BURST; k++) begin
                DATA = d;
                BE   = 2'b11;
                tick();
                model_beat(DATA, BE);
                d = d + 16'd1;
                if (k == MAX_BURST - 1) begin
                    checks++;
                    if (RD_N !== 1'b0) begin
                        errors++;
                        $display("FAIL maxb_early_release burst %0d got RD_N=%b exp 0", b, RD_N);
                    end
                end
            end
            checks++;
            if ({OE_N, RD_N} !== 2'b11) begin
                errors++;
                $display("FAIL maxb_forced_release burst %0d got %b exp 11", b, {OE_N, RD_N});
            end
            if (b == 0) begin
                tick();
                checks++;
                if ({OE_N, RD_N} !== 2'b11) begin
                    errors++;
                    $display("FAIL maxb_gap_idle got %b exp 11", {OE_N, RD_N});
                end
                tick();
                checks++;
                if ({OE_N, RD_N} !== 2'b01) begin
                    errors++;
                    $display("FAIL maxb_reentry_oe got %b exp 01", {OE_N, RD_N});
                end
                tick();
            end
        end
        RXF_N = 1'b1;
        tick();
        tick();
        checks++;
        if (word_cnt !== 32'd1024 || err_cnt !== 32'd0 || word_cnt !== m_word) begin
            errors++;
            $display("FAIL maxb_counts got w=%0d e=%0d exp w=1024 e=0", word_cnt, err_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] seq[4];
        seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        pulse_clr();
        foreach (seq[i]) begin
            stim_d.push_back(seq[i]);
            stim_be.push_back(2'b11);
        end
        send_burst();
        checks++;
        if (word_cnt !== 32'd4 || err_cnt !== 32'd0 || first_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap got w=%0d e=%0d fe=%b exp w=4 e=0 fe=0", word_cnt, err_cnt, first_err);
        end
    endtask

    task automatic test_errors();
        logic [15:0] seq[5];
        seq = '{16'd5, 16'd6, 16'd9, 16'd10, 16'd12};
        pulse_clr();
        foreach (seq[i]) begin
            stim_d.push_back(seq[i]);
            stim_be.push_back(2'b11);
        end
        send_burst();
        checks++;
        if (err_cnt !== 32'd2 || err_cnt !== m_err) begin
            errors++;
            $display("FAIL err_count got %0d exp 2", err_cnt);
        end
        checks++;
        if ({first_err, first_err_exp, first_err_got} !== {1'b1, 16'd7, 16'd9}) begin
            errors++;
            $display("FAIL err_first got fe=%b exp=%0d got=%0d exp fe=1 exp=7 got=9",
                     first_err, first_err_exp, first_err_got);
        end
    endtask

    task automatic test_clr_priority();
        pulse_clr();
        RXF_N = 1'b0;
        tick();
        tick();
        DATA = 16'd100; BE = 2'b11; tick(); model_beat(DATA, BE);
        DATA = 16'd101; tick(); model_beat(DATA, BE);
        DATA = 16'd500; clr = 1'b1; tick(); clr = 1'b0; model_clear();
        checks++;
        if (word_cnt !== 32'd0 || RD_N !== 1'b0) begin
            errors++;
            $display("FAIL clr_drop got w=%0d RD_N=%b exp w=0 RD_N=0", word_cnt, RD_N);
        end
        DATA = 16'd700; tick(); model_beat(DATA, BE);
        DATA = 16'd701; tick(); model_beat(DATA, BE);
        RXF_N = 1'b1;
        tick();
        tick();
        checks++;
        if (word_cnt !== m_word || err_cnt !== m_err || first_err !== m_first) begin
            errors++;
            $display("FAIL clr_reseed got w=%0d e=%0d fe=%b exp w=%0d e=%0d fe=%b",
                     word_cnt, err_cnt, first_err, m_word, m_err, m_first);
        end
    endtask

    task automatic test_be_err_and_reset();
        pulse_clr();
        RXF_N = 1'b0;
        tick();
        tick();
        DATA = 16'd3;      BE = 2'b11; tick(); model_beat(DATA, BE);
        DATA = 16'hAAAA;   BE = 2'b01; tick(); model_beat(DATA, BE);
        DATA = 16'd4;      BE = 2'b11; tick(); model_beat(DATA, BE);
        checks++;
        if ({be_err_cnt, err_cnt, word_cnt} !== {32'd1, 32'd0, 32'd2}) begin
            errors++;
            $display("FAIL be_err got b=%0d e=%0d w=%0d exp b=1 e=0 w=2",
                     be_err_cnt, err_cnt, word_cnt);
        end
        // Still mid-burst: drop reset between clock edges.
        #2;
        RESETN = 1'b0;
        #1;
        checks++;
        if ({OE_N, RD_N, rd_busy} !== 3'b110) begin
            errors++;
            $display("FAIL reset_midburst_strobes got %b exp 110", {OE_N, RD_N, rd_busy});
        end
        checks++;
        if ({word_cnt, err_cnt, be_err_cnt, first_err} !== '0) begin
            errors++;
            $display("FAIL reset_midburst_stats got w=%0d e=%0d b=%0d fe=%b exp all 0",
                     word_cnt, err_cnt, be_err_cnt, first_err);
        end
        RXF_N = 1'b1;
        model_clear();
        @(negedge CLK);
        RESETN = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [15:0] d;
        int          n;
        int          r;
        pulse_clr();
        d = 16'($urandom);
        for (int b = 0; b < 30; b++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    stim_d.push_back(16'($urandom));
                    stim_be.push_back(2'($urandom_range(0, 2)));
                end else if (r == 1) begin
                    d = 16'($urandom);
                    stim_d.push_back(d);
                    stim_be.push_back(2'b11);
                    d = d + 16'd1;
                end else begin
                    stim_d.push_back(d);
                    stim_be.push_back(2'b11);
                    d = d + 16'd1;
                end
            end
            send_burst();
            checks++;
            if (word_cnt !== m_word || err_cnt !== m_err || be_err_cnt !== m_be) begin
                errors++;
                $display("FAIL rand_counts burst %0d got w=%0d e=%0d b=%0d exp w=%0d e=%0d b=%0d",
                         b, word_cnt, err_cnt, be_err_cnt, m_word, m_err, m_be);
            end
            checks++;
            if ({first_err, first_err_exp, first_err_got} !== {m_first, m_fexp, m_fgot}) begin
                errors++;
                $display("FAIL rand_first burst %0d got %b/%h/%h exp %b/%h/%h", b,
                         first_err, first_err_exp, first_err_got, m_first, m_fexp, m_fgot);
            end
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 7) == 0) pulse_clr();
        end
    endtask

`ifdef FIFO_RD_FWD_EN
    task automatic test_fwd();
        logic [15:0] base;
        int          pulses;
        pulse_clr();
        base      = 16'($urandom);
        pulses    = 0;
        fwd_ready = 1'b1;
        RXF_N     = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            DATA = base + 16'(i);
            BE   = 2'b11;
            tick();
            model_beat(DATA, BE);
            if (fwd_valid === 1'b1) pulses++;
            checks++;
            if (fwd_valid !== 1'b1 || fwd_data !== base + 16'(i)) begin
                errors++;
                $display("FAIL fwd_data beat %0d got v=%b d=%h exp v=1 d=%h",
                         i, fwd_valid, fwd_data, base + 16'(i));
            end
        end
        fwd_ready = 1'b0;
        DATA      = base + 16'd3;
        tick();
        checks++;
        if ({OE_N, RD_N, fwd_valid} !== 3'b110 || word_cnt !== 32'd3) begin
            errors++;
            $display("FAIL fwd_stall_exit got strobes=%b v=%b w=%0d exp 11 v=0 w=3",
                     {OE_N, RD_N}, fwd_valid, word_cnt);
        end
        RXF_N     = 1'b1;
        fwd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (fwd_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL fwd_pulses got %0d exp 3", pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_burst();
        test_max_burst();
        test_wrap();
        test_errors();
        test_clr_priority();
        test_be_err_and_reset();
        test_random();
`ifdef FIFO_RD_FWD_EN
        test_fwd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
